ram128_wb_ctrl: RTL and testbench
=================================

Name: ram128_wb_ctrl

Overview:
- Wishbone classic slave front-end that sits directly upstream of the RAM128 SRAM macro.
- Decodes a 512-byte window, drives the macro's EN0/A0/Di0/WE0 pins and captures Do0.
- Returns ack or err to the bus master.
- Sequences the macro's one-cycle read latency with a small state machine.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base of the RAM window; bits [8:0] ignored.
- SEL_WIDTH, 4, byte lanes per word; fixed to 4 for RAM128.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1=write, 0=read.
- wb_sel_i  in  4  byte-lane selects.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  transfer-complete pulse, registered.
- wb_err_o  out  1  address-miss pulse, registered.
- ram_en0  out  1  to RAM128 EN0.
- ram_a0  out  7  to RAM128 A0 (word address).
- ram_di0  out  32  to RAM128 Di0.
- ram_we0  out  4  to RAM128 WE0 (per-byte write enable).
- ram_do0  in  32  from RAM128 Do0; valid the cycle after an enabled read edge.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State=IDLE.
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - ram_en0=0, ram_we0=0; ram_a0 and ram_di0 driven 0.
- Request: req = wb_cyc_i & wb_stb_i.
- Hit: hit = (wb_adr_i[31:9] == BASE_ADDR[31:9]).
- Word address: wb_adr_i[8:2]. wb_adr_i[1:0] is ignored.
- RAM pins are combinational from the bus, and only in IDLE with req&hit:
  - ram_en0 = 1.
  - ram_a0 = wb_adr_i[8:2].
  - ram_di0 = wb_dat_i.
  - ram_we0 = wb_we_i ? wb_sel_i : 4'b0000.
  - In every other state and condition: ram_en0=0 and ram_we0=0.
- States: IDLE, RD_WAIT, RESP.
- IDLE:
  - req & hit & wb_we_i: the write commits at this edge. Next state RESP, wb_ack_o<=1.
  - req & hit & !wb_we_i: the RAM samples the read at this edge. Next state RD_WAIT.
  - req & !hit: no RAM access. Next state RESP, wb_err_o<=1.
  - !req: stay in IDLE.
- RD_WAIT:
  - If wb_cyc_i=1: wb_dat_o<=ram_do0, wb_ack_o<=1, next state RESP.
  - If wb_cyc_i=0 (master abort): no ack, wb_dat_o unchanged, next state IDLE.
- RESP:
  - wb_ack_o and wb_err_o are driven 0 at this edge, so each pulse lasts exactly 1 cycle.
  - Next state IDLE unconditionally.
  - stb still high during the ack cycle is ignored; no double-accept.
- Latency, counted from the request-presented cycle to the ack-high cycle:
  - Write: 1 cycle.
  - Read: 2 cycles.
  - Miss: err high after 1 cycle.
- Back-to-back: a new request is accepted in the cycle after RESP. Minimum spacing is 2 cycles (write) and 3 cycles (read).
- wb_sel_i=0 on a write: ram_en0=1, ram_we0=0, memory unchanged, ack still returned.
- wb_sel_i on a read: ignored; the full 32-bit word is returned.
- wb_ack_o and wb_err_o are never high together.
- wb_dat_o holds its last read value until the next completed read.
- Reset mid-operation: an in-flight read is dropped with no ack. A write whose edge coincided with reset assertion is not guaranteed.
- Word address wrap: 7'h7F is the top word. There is no auto-increment or burst support; each transfer is independent.

Test Plan:
- Write then read:
  - Write 32'hDEADBEEF to 0x3000_0010 with sel=4'hF: ram_en0=1, ram_a0=7'h04, ram_we0=4'hF in the request cycle; ack 1 cycle later.
  - Read the same address: ack 2 cycles after request; wb_dat_o=32'hDEADBEEF.
- Byte lanes:
  - Preload 32'h11223344 at word 7'h7F (0x3000_01FC).
  - Write 32'hAABBCCDD with sel=4'b0101.
  - Read back 32'h11BB33DD.
- Miss:
  - Access to 0x3000_0200, read and write: wb_err_o=1 for exactly 1 cycle after 1 cycle.
  - ram_en0 stays 0 throughout; wb_ack_o stays 0.
- Abort:
  - Issue a read, then drop wb_cyc_i in the RD_WAIT cycle: no ack, wb_dat_o unchanged, FSM back in IDLE.
  - A following write is accepted normally.
- Back-to-back with stb held high across ack:
  - Exactly one ack per transfer; the next transfer is accepted only in the cycle after RESP.
  - Four sequential writes each ack with 2-cycle spacing.
- Reset:
  - Assert resetn=0 asynchronously in the RD_WAIT cycle: all outputs 0 immediately, no ack after release.
  - The first request after release behaves as from IDLE.

Source files
------------

// File: rtl/ram128_wb_ctrl.sv
// Wishbone classic slave in front of the RAM128 SRAM macro.
// Decodes a 512-byte window, drives the macro pins and sequences its one-cycle read latency.
module ram128_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SEL_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [SEL_WIDTH-1:0] wb_sel_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 ram_en0,
    output logic [6:0]           ram_a0,
    output logic [31:0]          ram_di0,
    output logic [SEL_WIDTH-1:0] ram_we0,
    input  logic [31:0]          ram_do0
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic        w_req;
    logic        w_hit;
    logic        w_access;
    logic        w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_hit    = (wb_adr_i[31:9] == BASE_ADDR[31:9]);
    // Gated by resetn so the macro sees no enable while reset is held with a request on the bus.
    assign w_access = resetn & (r_state == IDLE) & w_req & w_hit;
    assign w_unused = &{1'b0, wb_adr_i[1:0]};

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;

    always_comb begin
        ram_en0 = 1'b0;
        ram_a0  = '0;
        ram_di0 = '0;
        ram_we0 = '0;
        if (w_access) begin
            ram_en0 = 1'b1;
            ram_a0  = wb_adr_i[8:2];
            ram_di0 = wb_dat_i;
            ram_we0 = wb_we_i ? wb_sel_i : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = (w_hit && !wb_we_i) ? RD_WAIT : RESP;
                end
            end
            RD_WAIT: w_state_nxt = wb_cyc_i ? RESP : IDLE;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ack/err default low every edge, which makes each pulse exactly one cycle wide.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (!w_hit) begin
                            r_err <= 1'b1;
                        end else if (wb_we_i) begin
                            r_ack <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (wb_cyc_i) begin
                        r_ack <= 1'b1;
                        r_dat <= ram_do0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram128_wb_ctrl.sv
// Directed bench for ram128_wb_ctrl with a behavioural RAM128 macro and a read-data scoreboard.
module tb_ram128_wb_ctrl;

    logic        clk;
    logic        resetn;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic [31:0] dat_o;
    logic        ack, err;
    logic        ram_en0;
    logic [6:0]  ram_a0;
    logic [31:0] ram_di0;
    logic [3:0]  ram_we0;
    logic [31:0] ram_do0;

    logic [31:0] mem [128];
    logic [31:0] shadow [128];
    logic [31:0] q_exp [$];
    logic [31:0] last_dat;
    int          n_vec;
    int          n_miss;

    ram128_wb_ctrl #(.BASE_ADDR(32'h3000_0000), .SEL_WIDTH(4)) dut (
        .CLK      (clk),
        .resetn   (resetn),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .ram_en0  (ram_en0),
        .ram_a0   (ram_a0),
        .ram_di0  (ram_di0),
        .ram_we0  (ram_we0),
        .ram_do0  (ram_do0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM128: byte-enabled write, registered read on every enabled edge.
    always @(posedge clk) begin
        if (ram_en0) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we0[b]) mem[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
            end
            ram_do0 <= mem[ram_a0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
    endtask

    function automatic logic is_hit(input logic [31:0] a);
        return a[31:9] == 23'(32'h3000_0000 >> 9);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit keep);
        logic h;
        h = is_hit(a);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
        #1;
        chk("wr_en0", 32'(ram_en0), 32'(h));
        chk("wr_we0", 32'(ram_we0), h ? 32'(s) : 32'h0);
        if (h) begin
            chk("wr_a0", 32'(ram_a0), 32'(a[8:2]));
            chk("wr_di0", ram_di0, d);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) shadow[a[8:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
        step;
        chk("wr_ack", 32'(ack), 32'(h));
        chk("wr_err", 32'(err), 32'(!h));
        #1;
        chk("wr_resp_en0", 32'(ram_en0), 32'h0);
        if (!keep) bus_idle;
        step;
        chk("wr_ack_end", 32'(ack), 32'h0);
        chk("wr_err_end", 32'(err), 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] s);
        logic h;
        h = is_hit(a);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; dat_i = 32'h5A5A_5A5A; sel = s;
        #1;
        chk("rd_en0", 32'(ram_en0), 32'(h));
        chk("rd_we0", 32'(ram_we0), 32'h0);
        if (h) begin
            chk("rd_a0", 32'(ram_a0), 32'(a[8:2]));
            q_exp.push_back(shadow[a[8:2]]);
            step;
            chk("rd_wait_ack", 32'(ack), 32'h0);
            chk("rd_wait_err", 32'(err), 32'h0);
            #1;
            chk("rd_wait_en0", 32'(ram_en0), 32'h0);
            step;
            chk("rd_ack", 32'(ack), 32'h1);
            chk("rd_err", 32'(err), 32'h0);
            last_dat = q_exp.pop_front();
            chk("rd_dat", dat_o, last_dat);
        end else begin
            step;
            chk("miss_err", 32'(err), 32'h1);
            chk("miss_ack", 32'(ack), 32'h0);
            chk("miss_dat", dat_o, last_dat);
        end
        #1;
        chk("rd_resp_en0", 32'(ram_en0), 32'h0);
        bus_idle;
        step;
        chk("rd_ack_end", 32'(ack), 32'h0);
        chk("rd_err_end", 32'(err), 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        last_dat = 32'h0;
        for (int i = 0; i < 128; i++) shadow[i] = 32'h0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        resetn = 1'b0;
        bus_idle;
        step;
        step;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_en0", 32'(ram_en0), 32'h0);
        chk("rst_we0", 32'(ram_we0), 32'h0);
        chk("rst_a0", 32'(ram_a0), 32'h0);
        chk("rst_di0", ram_di0, 32'h0);
        #2 resetn = 1'b1;
        step;

        // Write then read.
        wr(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(32'h3000_0010, 4'hF);
        chk("wr_rd_value", dat_o, 32'hDEAD_BEEF);

        // Byte lanes on the top word.
        wr(32'h3000_01FC, 32'h1122_3344, 4'hF, 1'b0);
        wr(32'h3000_01FC, 32'hAABB_CCDD, 4'b0101, 1'b0);
        rd(32'h3000_01FC, 4'h0);
        chk("byte_lane_value", dat_o, 32'h11BB_33DD);

        // sel=0 write leaves memory unchanged but still acks.
        wr(32'h3000_0020, 32'hCAFE_F00D, 4'hF, 1'b0);
        wr(32'h3000_0020, 32'h1234_5678, 4'h0, 1'b0);
        rd(32'h3000_0022, 4'h3);
        chk("sel0_value", dat_o, 32'hCAFE_F00D);

        // Misses, write and read.
        wr(32'h3000_0200, 32'hFFFF_FFFF, 4'hF, 1'b0);
        rd(32'h3000_0200, 4'hF);
        rd(32'h2000_0010, 4'hF);

        // Master abort in RD_WAIT.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
        step;
        bus_idle;
        step;
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_dat", dat_o, last_dat);
        step;
        chk("abort_ack2", 32'(ack), 32'h0);
        wr(32'h3000_0030, 32'h0BAD_C0DE, 4'hF, 1'b0);

        // Back-to-back writes with stb held across every ack.
        for (int i = 0; i < 4; i++) begin
            wr(32'h3000_0040 + 32'(4 * i), 32'hA5A5_0000 + 32'(i * 32'h0101), 4'hF, 1'b1);
        end
        bus_idle;
        step;
        chk("b2b_ack_idle", 32'(ack), 32'h0);
        for (int i = 0; i < 4; i++) rd(32'h3000_0040 + 32'(4 * i), 4'hF);
        rd(32'h3000_0030, 4'hF);

        // Asynchronous reset in RD_WAIT drops the read.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
        step;
        resetn = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_dat", dat_o, 32'h0);
        chk("mid_rst_en0", 32'(ram_en0), 32'h0);
        chk("mid_rst_a0", 32'(ram_a0), 32'h0);
        last_dat = 32'h0;
        bus_idle;
        #2 resetn = 1'b1;
        step;
        chk("post_rst_ack", 32'(ack), 32'h0);
        step;
        chk("post_rst_ack2", 32'(ack), 32'h0);
        chk("post_rst_dat", dat_o, 32'h0);
        rd(32'h3000_0010, 4'hF);
        chk("post_rst_value", dat_o, 32'hDEAD_BEEF);
        wr(32'h3000_0050, 32'h7777_8888, 4'hF, 1'b0);
        rd(32'h3000_0050, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
